// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with exact occupancy count, threshold flags, sticky error flags and flush.
// Define SYNC_FIFO_FWFT_EN for a first-word-fall-through read path (default: registered read, latency 1).
module sync_fifo_flags #(
    parameter int DATA_WIDTH       = 8,
    parameter int ADDR_WIDTH       = 4,
    parameter int ALMOST_FULL_LVL  = 12,
    parameter int ALMOST_EMPTY_LVL = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH + 1)'(ALMOST_FULL_LVL);
    localparam logic [ADDR_WIDTH:0] AE_CNT   = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_LVL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_set;
    logic                  udf_set;

    // Flags decode straight from the registered count, so they are exact.
    assign count        = count_q;
    assign full         = (count_q == FULL_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);

    assign wr_acc  = wr_en & ~full & ~flush;
    assign rd_acc  = rd_en & ~empty & ~flush;
    assign ovf_set = wr_en & full & ~flush;
    assign udf_set = rd_en & empty & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + (ADDR_WIDTH + 1)'(1);
                2'b01:   count_q <= count_q - (ADDR_WIDTH + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= din;
    end

    // A new error event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_set | (overflow & ~clr_err);
            underflow <= udf_set | (underflow & ~clr_err);
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented combinationally; driven to zero while empty to keep the bus quiet.
    assign dout = empty ? '0 : mem[rd_ptr];
`else
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= mem[rd_ptr];
        end
    end

    assign dout = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: directed scenarios plus random traffic against a queue-based model.
// Builds for either read mode depending on SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_flags;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          full;
    logic          almost_full;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          empty;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          clr_err;
    logic          overflow;
    logic          underflow;

    sync_fifo_flags #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .ALMOST_FULL_LVL(AF), .ALMOST_EMPTY_LVL(AE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_en(wr_en), .din(din), .full(full), .almost_full(almost_full),
        .rd_en(rd_en), .dout(dout), .empty(empty), .almost_empty(almost_empty),
        .count(count), .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_ovf;
    logic          m_udf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    // Applies the FIFO rules for one rising edge using the inputs currently driven.
    task automatic model_edge();
        int n;
        logic wa, ra;
        logic [DW-1:0] d;
        n  = q.size();
        wa = wr_en && (n < DEPTH) && !flush;
        ra = rd_en && (n > 0) && !flush;
        if (wr_en && n == DEPTH && !flush) m_ovf = 1'b1;
        else if (clr_err)                  m_ovf = 1'b0;
        if (rd_en && n == 0 && !flush)     m_udf = 1'b1;
        else if (clr_err)                  m_udf = 1'b0;
        if (flush) begin
            q.delete();
        end else begin
            if (ra) begin
                d = q.pop_front();
                m_dout = d;
            end
            if (wa) q.push_back(din);
        end
    endtask

    task automatic compare_model();
        int n;
        n = q.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
        if (n > 0) chk("dout_fwft", 32'(dout), 32'(q[0]));
`else
        chk("dout", 32'(dout), 32'(m_dout));
`endif
    endtask

    task automatic drive(input logic w, input logic [DW-1:0] d, input logic r,
                         input logic f, input logic c);
        wr_en   = w;
        din     = d;
        rd_en   = r;
        flush   = f;
        clr_err = c;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        compare_model();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_almost_empty", 32'(almost_empty), 1);
        chk("rst_full", 32'(full), 0);
        rst_n = 1'b1;

        // Fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
            step();
            chk("fill_count", 32'(count), i);
            chk("fill_almost_full", 32'(almost_full), (i >= 12) ? 1 : 0);
        end
        chk("full_at_16", 32'(full), 1);

        // Overflow and sticky clear
        drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        step();
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 16);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();
        chk("ovf_cleared", 32'(overflow), 0);
        drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        step();
        chk("ovf_set_wins", 32'(overflow), 1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();

        // Drain, checking order and absence of corruption
        for (int i = 1; i <= 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            chk("rd_seq", 32'(dout), i);
`endif
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            step();
`ifndef SYNC_FIFO_FWFT_EN
            chk("rd_seq", 32'(dout), i);
`endif
        end
        chk("drained_empty", 32'(empty), 1);

        // Underflow, then read+write on empty
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step();
        chk("udf_set", 32'(underflow), 1);
        chk("udf_count", 32'(count), 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("udf_dout_hold", 32'(dout), 32'h10);
`endif
        drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        step();
        chk("empty_rw_count", 32'(count), 1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step();

        // Steady state at 8 across pointer wrap
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, DW'(8'h60 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, DW'(8'h80 + i), 1'b1, 1'b0, 1'b0);
            step();
            chk("steady_count", 32'(count), 8);
        end

        // Full with read+write: read wins, write rejected
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        step();
        chk("full_rw_count", 32'(count), 15);
        chk("full_rw_ovf", 32'(overflow), 1);

        // Flush priority
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        step();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, DW'(8'h20 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        step();
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_no_udf", 32'(underflow), 0);

        // Async reset mid-burst
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DW'(8'h40 + i), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_full", 32'(full), 0);
        chk("arst_udf", 32'(underflow), 0);
        chk("arst_almost_empty", 32'(almost_empty), 1);
`ifndef SYNC_FIFO_FWFT_EN
        chk("arst_dout", 32'(dout), 0);
`endif
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        compare_model();

        // Single-word latency
        drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        step();
        chk("single_empty", 32'(empty), 0);
`ifdef SYNC_FIFO_FWFT_EN
        chk("fwft_dout", 32'(dout), 32'h3C);
`else
        chk("std_dout_not_yet", 32'(dout), 0);
`endif
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step();
        chk("single_pop_empty", 32'(empty), 1);
`ifndef SYNC_FIFO_FWFT_EN
        chk("std_dout_after_rd", 32'(dout), 32'h3C);
`endif

        // Random traffic with fill-biased and drain-biased phases
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = ((i / 150) % 2 == 0) ? 70 : 30;
            drive($urandom_range(0, 99) < wp,
                  DW'($urandom),
                  $urandom_range(0, 99) < (100 - wp),
                  $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 5);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
